// File: rtl/booth_mul_seq_if.sv
// rtl/booth_mul_seq_if.sv - operand, encoder and product handshake bundle for booth_mul_seq
interface booth_mul_seq_if #(
    parameter int MUL_WIDTH = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [MUL_WIDTH-1:0]     in_a;
    logic [MUL_WIDTH-1:0]     in_b;
    logic [MUL_WIDTH-1:0]     enc_a_dat;
    logic [2:0]               enc_b_bits;
    logic [MUL_WIDTH:0]       enc_pp;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*MUL_WIDTH-1:0]   out_product;

    modport slave (
        input  in_valid, in_a, in_b, enc_pp, out_ready,
        output in_ready, enc_a_dat, enc_b_bits, out_valid, out_product
    );

    modport master (
        output in_valid, in_a, in_b, enc_pp, out_ready,
        input  in_ready, enc_a_dat, enc_b_bits, out_valid, out_product
    );
endinterface

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-4 Booth multiplier with its partial-product encoder

// Combinational radix-4 Booth encoder: maps one 3-bit window to a digit in
// {-2,-1,0,+1,+2} and returns digit*a as a (W+1)-bit signed value.
module booth_pp_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [2:0]   i_bits,
    output logic [W:0]   o_pp
);
    logic [W:0] w_a_ext;
    logic [W:0] w_a_dbl;

    assign w_a_ext = {i_a[W-1], i_a};
    assign w_a_dbl = {i_a, 1'b0};

    // Digit selection and negation for the current window
    always_comb begin
        o_pp = '0;
        case (i_bits)
            3'b001, 3'b010: o_pp = w_a_ext;
            3'b011:         o_pp = w_a_dbl;
            3'b100:         o_pp = -w_a_dbl;
            3'b101, 3'b110: o_pp = -w_a_ext;
            default:        o_pp = '0;
        endcase
    end
endmodule

module booth_mul_seq #(
    parameter int MUL_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    booth_mul_seq_if.slave bus
);
    localparam int W  = MUL_WIDTH;
    localparam int P  = 2 * MUL_WIDTH;
    localparam int CW = (W / 2 > 1) ? $clog2(W / 2) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W / 2 - 1);
    localparam logic [W-1:0]  A_MIN     = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-2:0]   r_b_rem;
    logic [2:0]     r_b_bits;
    logic [CW-1:0]  r_cnt;
    logic [P-1:0]   r_acc;

    logic           w_accept;
    logic           w_last;
    logic           w_pp_sign;
    logic [P-1:0]   w_pp_ext;
    logic [P-1:0]   w_pp_shift;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == LAST_STEP);

    // A -2 digit applied to the most negative multiplicand gives +2^W, which
    // reads as negative in W+1 bits; that one case must be zero-extended so the
    // (-2^(W-1))^2 product comes out right.
    assign w_pp_sign  = bus.enc_pp[W] && !((r_b_bits == 3'b100) && (r_a == A_MIN));
    assign w_pp_ext   = {{(P-W-1){w_pp_sign}}, bus.enc_pp};
    assign w_pp_shift = w_pp_ext << {r_cnt, 1'b0};

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.out_product = r_acc;
    assign bus.enc_a_dat   = r_a;
    assign bus.enc_b_bits  = r_b_bits;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept, walk W/2 Booth steps, hold product until taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, window stepping and partial-product accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b_rem  <= '0;
            r_b_bits <= 3'b000;
            r_cnt    <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= bus.in_a;
                        r_b_bits <= {bus.in_b[1:0], 1'b0};
                        r_b_rem  <= bus.in_b[W-1:1];
                        r_cnt    <= '0;
                        r_acc    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= r_acc + w_pp_shift;
                    r_b_rem  <= {{2{r_b_rem[W-2]}}, r_b_rem[W-2:2]};
                    r_b_bits <= w_last ? 3'b000 : r_b_rem[2:0];
                    r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
                end
                default: begin
                    r_b_bits <= 3'b000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - directed and random checks of booth_mul_seq with a real encoder
module tb_booth_mul_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_mul_seq_if #(.MUL_WIDTH(W)) bus ();

    booth_mul_seq #(.MUL_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    booth_pp_enc #(.W(W)) u_enc (
        .i_a    (bus.enc_a_dat),
        .i_bits (bus.enc_b_bits),
        .o_pp   (bus.enc_pp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 40), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_timeout"}, 32'(n < 40), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input logic [15:0] exp, input int stall, input string tag);
        wait_valid(tag);
        repeat (stall) @(negedge clk);
        check(tag, 32'(bus.out_product), 32'(exp));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    int acc_cyc [4];
    logic signed [7:0]  ra;
    logic signed [7:0]  rb;
    logic signed [15:0] rp;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_product", 32'(bus.out_product), 32'd0);
        check("rst_enc_a", 32'(bus.enc_a_dat), 32'd0);
        check("rst_enc_b", 32'(bus.enc_b_bits), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3*5 with latency: accept edge, then 4 RUN edges before out_valid
        bus.in_a = 8'd3; bus.in_b = 8'd5; bus.in_valid = 1'b1;
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t1_run_in_ready", 32'(bus.in_ready), 32'd0);
        check("t1_enc_a", 32'(bus.enc_a_dat), 32'd3);
        check("t1_enc_b0", 32'(bus.enc_b_bits), 32'b010);
        repeat (3) @(negedge clk);
        check("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_product", 32'(bus.out_product), 32'h000F);
        check("t1_done_enc_b", 32'(bus.enc_b_bits), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t1_valid_drop", 32'(bus.out_valid), 32'd0);
        check("t1_idle_ready", 32'(bus.in_ready), 32'd1);

        // Corner operands
        send(8'h80, 8'h80, "t2_mm"); recv(16'h4000, 0, "t2_min_min");
        send(8'h80, 8'h7F, "t2_mx"); recv(16'hC080, 0, "t2_min_max");
        send(8'h00, 8'hFF, "t2_zn"); recv(16'h0000, 0, "t2_zero_neg1");
        send(8'hFF, 8'hFF, "t2_nn"); recv(16'h0001, 0, "t2_neg1_neg1");

        // Back-pressure in DONE with a held in_valid behind it
        send(8'hFB, 8'h06, "t3_a");
        bus.in_a = 8'd2; bus.in_b = 8'd3; bus.in_valid = 1'b1;
        wait_valid("t3_wait");
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t3_hold_product", 32'(bus.out_product), 32'hFFE2);
            check("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        check("t3_handshake_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t3_idle_valid", 32'(bus.out_valid), 32'd0);
        check("t3_idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t3_second_accepted", 32'(bus.in_ready), 32'd0);
        check("t3_second_enc_a", 32'(bus.enc_a_dat), 32'd2);
        recv(16'h0006, 0, "t3_second_product");

        // Reset during the second RUN cycle aborts the operation
        bus.in_a = 8'd5; bus.in_b = 8'd5; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_in_ready", 32'(bus.in_ready), 32'd1);
        check("t4_out_valid", 32'(bus.out_valid), 32'd0);
        check("t4_enc_b", 32'(bus.enc_b_bits), 32'd0);
        repeat (6) @(negedge clk);
        check("t4_no_product", 32'(bus.out_valid), 32'd0);
        send(8'd7, 8'hF7, "t4_b"); recv(16'hFFC1, 0, "t4_7_x_m9");

        // Back-to-back with in_valid and out_ready held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            case (k)
                0: begin bus.in_a = 8'd12;  bus.in_b = 8'hFD; end
                1: begin bus.in_a = 8'hF9;  bus.in_b = 8'hF9; end
                2: begin bus.in_a = 8'd100; bus.in_b = 8'd100; end
                default: begin bus.in_a = 8'h80; bus.in_b = 8'd1; end
            endcase
            while (!bus.in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("t5_accept_timeout", 32'(n < 40), 32'd1);
            acc_cyc[k] = cyc;
            @(negedge clk);
            wait_valid("t5_wait");
            case (k)
                0: check("t5_p0", 32'(bus.out_product), 32'hFFDC);
                1: check("t5_p1", 32'(bus.out_product), 32'h0031);
                2: check("t5_p2", 32'(bus.out_product), 32'h2710);
                default: check("t5_p3", 32'(bus.out_product), 32'hFF80);
            endcase
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check("t5_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd6);
        end

        // Random signed pairs with random consumer stalls
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = ra * rb;
            send(ra, rb, "t6_send");
            recv(rp, int'($urandom_range(0, 3)), "t6_random_product");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
